// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU op encoding, instruction field positions and sequencer state type
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 3;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 7;
  localparam int RS2_HI = 6;
  localparam int RS2_LO = 4;
  typedef enum logic [2:0] {IDLE, READ1, READ2, EXEC, WB} state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute controller; ports: instr handshake + halt in, regfile read/write, ALU drive, busy/illegalOp/retiredCount status
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [15:0]       instrWord,
  input  logic              halt,
  output logic [REG_AW-1:0] regReadAddr,
  input  logic [DATA_W-1:0] regReadData,
  output logic              regWrite,
  output logic [REG_AW-1:0] regWriteAddr,
  output logic [DATA_W-1:0] regWriteData,
  output logic [2:0]        aluControl,
  output logic [DATA_W-1:0] rs1Value,
  output logic [DATA_W-1:0] rs2Value,
  input  logic [DATA_W-1:0] rdValue,
  output logic              busy,
  output logic              illegalOp,
  output logic [15:0]       retiredCount
);
  state_t state, state_nx;
  logic [15:0] instr_q;
  logic [DATA_W-1:0] op1_q, op2_q, result_q;
  logic [15:0] retired_q;
  logic [2:0] op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic legal;
  logic unused_bits;
  assign op = instr_q[OP_HI:OP_LO];
  assign rd = REG_AW'(instr_q[RD_HI:RD_LO]);
  assign rs1 = REG_AW'(instr_q[RS1_HI:RS1_LO]);
  assign rs2 = REG_AW'(instr_q[RS2_HI:RS2_LO]);
  assign legal = op_legal(op);
  assign unused_bits = ^instr_q[3:0];
  assign busy = state != IDLE;
  assign rs1Value = op1_q;
  assign rs2Value = op2_q;
  assign retiredCount = retired_q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      instr_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      result_q <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && instrValid && instrReady) instr_q <= instrWord;
      if (state == READ1) op1_q <= regReadData;
      if (state == READ2) op2_q <= regReadData;
      if (state == EXEC && legal) result_q <= rdValue;
      if (state == WB) retired_q <= retired_q + 16'd1;
    end
  end
  // instrReady is gated by rstN so every output reads 0 while reset is held
  always_comb begin
    state_nx = state;
    instrReady = 1'b0;
    regReadAddr = '0;
    regWrite = 1'b0;
    regWriteAddr = '0;
    regWriteData = '0;
    aluControl = OP_ADD;
    illegalOp = 1'b0;
    case (state)
      IDLE: begin
        instrReady = rstN && !halt;
        state_nx = (instrValid && instrReady) ? READ1 : IDLE;
      end
      READ1: begin
        regReadAddr = rs1;
        state_nx = READ2;
      end
      READ2: begin
        regReadAddr = rs2;
        state_nx = EXEC;
      end
      EXEC: begin
        aluControl = op;
        illegalOp = !legal;
        state_nx = legal ? WB : IDLE;
      end
      WB: begin
        regWrite = 1'b1;
        regWriteAddr = rd;
        regWriteData = result_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed + random checks of alu_sequencer against a register-level instruction model
module tb_alu_sequencer;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic instrValid = 1'b0;
  logic halt = 1'b0;
  logic [15:0] instrWord = '0;
  logic instrReady, regWrite, busy, illegalOp;
  logic [2:0] regReadAddr, regWriteAddr, aluControl;
  logic [15:0] regReadData, regWriteData, rs1Value, rs2Value, rdValue, retiredCount;
  logic [15:0] rf [8];
  logic [15:0] ref_rf [8];
  logic [15:0] ref_cnt = '0;
  logic pre_wr = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  int tests = 0;
  int fails = 0;
  int wr_seen = 0;
  int last_wait = 0;
  always #5 clk = ~clk;
  alu_sequencer dut (
    .clk(clk), .rstN(rstN), .instrValid(instrValid), .instrReady(instrReady),
    .instrWord(instrWord), .halt(halt), .regReadAddr(regReadAddr), .regReadData(regReadData),
    .regWrite(regWrite), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
    .aluControl(aluControl), .rs1Value(rs1Value), .rs2Value(rs2Value), .rdValue(rdValue),
    .busy(busy), .illegalOp(illegalOp), .retiredCount(retiredCount)
  );
  assign regReadData = rf[regReadAddr];
  always_comb begin
    case (aluControl)
      3'd0: rdValue = rs1Value + rs2Value;
      3'd1: rdValue = rs1Value - rs2Value;
      3'd2: rdValue = rs1Value | rs2Value;
      3'd3: rdValue = rs1Value & rs2Value;
      default: rdValue = rs1Value ^ rs2Value;
    endcase
  end
  always @(posedge clk) begin
    if (regWrite) begin
      rf[regWriteAddr] <= regWriteData;
      wr_seen <= wr_seen + 1;
    end else if (pre_wr) rf[pre_addr] <= pre_data;
  end
  function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      default: return a ^ b;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    pre_wr = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_wr = 1'b0;
    ref_rf[addr] = data;
  endtask
  task automatic check_rf();
    for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), rf[i], ref_rf[i]);
  endtask
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit chain);
    int n;
    logic legal;
    logic [15:0] a, b, r;
    n = 0;
    legal = op <= 3'd4;
    a = ref_rf[rs1];
    b = ref_rf[rs2];
    r = model(op, a, b);
    instrWord = {op, rd, rs1, rs2, 4'hA};
    instrValid = 1'b1;
    #1;
    while (!instrReady && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    last_wait = n;
    chk("accept_ready", instrReady, 1);
    @(negedge clk);
    if (!chain) instrValid = 1'b0;
    chk("read1_busy", busy, 1);
    chk("read1_notready", instrReady, 0);
    chk("read1_addr", regReadAddr, rs1);
    @(negedge clk);
    chk("read2_addr", regReadAddr, rs2);
    chk("read2_notready", instrReady, 0);
    @(negedge clk);
    chk("exec_alu", aluControl, op);
    chk("exec_a", rs1Value, a);
    chk("exec_b", rs2Value, b);
    chk("exec_illegal", illegalOp, !legal);
    chk("exec_nowrite", regWrite, 0);
    if (legal) begin
      @(negedge clk);
      chk("wb_write", regWrite, 1);
      chk("wb_addr", regWriteAddr, rd);
      chk("wb_data", regWriteData, r);
      chk("wb_illegal", illegalOp, 0);
      chk("wb_notready", instrReady, 0);
      ref_rf[rd] = r;
      ref_cnt = ref_cnt + 16'd1;
    end
    @(negedge clk);
    chk("idle_ready", instrReady, 1);
    chk("idle_busy", busy, 0);
    chk("idle_nowrite", regWrite, 0);
    chk("idle_illegal", illegalOp, 0);
    chk("retired", retiredCount, ref_cnt);
    check_rf();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ws;
    logic [15:0] c;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    #2 rstN = 1'b0;
    instrValid = 1'b1;
    #2;
    chk("rst_ready", instrReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write", regWrite, 0);
    chk("rst_illegal", illegalOp, 0);
    chk("rst_count", retiredCount, 0);
    chk("rst_alu", aluControl, 0);
    chk("rst_ops", {rs1Value, rs2Value}, 0);
    chk("rst_raddr", regReadAddr, 0);
    repeat (2) @(negedge clk);
    instrValid = 1'b0;
    rstN = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'(i * 16'h0111));
    preload(3'd1, 16'd5);
    preload(3'd2, 16'd7);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    chk("add_r3", rf[3], 16'h000C);
    chk("add_count", retiredCount, 16'd1);
    preload(3'd1, 16'd0);
    preload(3'd2, 16'd1);
    issue(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0);
    chk("sub_wrap", rf[4], 16'hFFFF);
    preload(3'd1, 16'd5);
    preload(3'd2, 16'd7);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1);
    issue(OP_XOR, 3'd5, 3'd3, 3'd1, 1'b0);
    chk("b2b_accept_cycle5", last_wait, 0);
    chk("b2b_r5", rf[5], 16'h0009);
    c = ref_cnt;
    issue(3'b110, 3'd7, 3'd1, 3'd2, 1'b0);
    chk("illegal_count", retiredCount, c);
    preload(3'd6, 16'h1234);
    @(negedge clk);
    instrWord = {OP_ADD, 3'd6, 3'd1, 3'd2, 4'h0};
    instrValid = 1'b1;
    #1 chk("mid_accept", instrReady, 1);
    @(negedge clk);
    instrValid = 1'b0;
    @(negedge clk);
    chk("mid_read2", regReadAddr, 2);
    ws = wr_seen;
    #1 rstN = 1'b0;
    #1;
    ref_cnt = '0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", instrReady, 0);
    chk("mid_rst_raddr", regReadAddr, 0);
    chk("mid_rst_ops", {rs1Value, rs2Value}, 0);
    chk("mid_rst_count", retiredCount, 0);
    chk("mid_rst_write", {regWrite, regWriteAddr, regWriteData}, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_nowrite", wr_seen, ws);
    chk("mid_rst_count_after", retiredCount, 0);
    check_rf();
    halt = 1'b1;
    instrWord = {OP_OR, 3'd6, 3'd1, 3'd2, 4'h0};
    instrValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("halt_ready", instrReady, 0);
      chk("halt_busy", busy, 0);
    end
    halt = 1'b0;
    issue(OP_OR, 3'd6, 3'd1, 3'd2, 1'b0);
    chk("halt_release_accept", last_wait, 0);
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    ref_cnt = 16'hFFFF;
    chk("wrap_preload", retiredCount, 16'hFFFF);
    issue(OP_AND, 3'd7, 3'd1, 3'd2, 1'b0);
    chk("wrap_zero", retiredCount, 16'h0000);
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    instrValid = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Multi-cycle execute controller for the CPU's 16-bit ALU.
- Accepts one register-register instruction word at a time over a valid/ready handshake.
- Reads both source operands through the register file's single read port, drives the ALU, and writes the result back.
- Sits between the fetch/decode front end and the ALU and register file instances, which remain separate at the top level.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- REG_AW, 3, register address width (8 registers)

Ports:
- clk  in  1  system clock, rising-edge
- rstN  in  1  asynchronous active-low reset
- instrValid  in  1  instrWord valid
- instrReady  out  1  sequencer can accept an instruction
- instrWord  in  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored
- halt  in  1  blocks acceptance of new instructions
- regReadAddr  out  REG_AW  register file read address
- regReadData  in  DATA_W  combinational read data for regReadAddr
- regWrite  out  1  write strobe
- regWriteAddr  out  REG_AW  write address
- regWriteData  out  DATA_W  write data
- aluControl  out  3  ALU op select
- rs1Value  out  DATA_W  ALU operand A
- rs2Value  out  DATA_W  ALU operand B
- rdValue  in  DATA_W  ALU result, combinational
- busy  out  1  high in any state other than IDLE
- illegalOp  out  1  one-cycle pulse on unsupported op
- retiredCount  out  16  count of written-back instructions, wraps

## Operation
- States: IDLE, READ1, READ2, EXEC, WB.
- IDLE:
  - instrReady = !halt.
  - On instrValid && instrReady, latch instrWord and go to READ1.
- READ1:
  - regReadAddr = rs1.
  - At the clock edge, capture regReadData into op1; go to READ2.
- READ2:
  - regReadAddr = rs2.
  - At the clock edge, capture regReadData into op2; go to EXEC.
- EXEC:
  - aluControl = latched op; rs1Value = op1; rs2Value = op2.
  - Legal op (000 add, 001 sub, 010 or, 011 and, 100 xor): capture rdValue into the result register; go to WB.
  - Illegal op (101–111): illegalOp = 1 this cycle; return to IDLE with no write and no count change.
- WB:
  - regWrite = 1; regWriteAddr = rd; regWriteData = result.
  - retiredCount increments by 1 at the edge, wrapping FFFF→0000.
  - Go to IDLE.
- Write decision is made by the sequencer's own op decode only; no write-enable is taken from the ALU.
- Outside EXEC, aluControl = 3'b000. rs1Value/rs2Value always reflect op1/op2.
- instrReady is 0 in every state other than IDLE.
- r0 is an ordinary register.
- Arithmetic is modulo 2^16; no carry or overflow outputs.

## Timing
- Reset (rstN low, asynchronous):
  - State goes to IDLE.
  - op1, op2, result, latched instruction and retiredCount go to 0.
  - All outputs go to 0, including instrReady.
  - instrReady may assert from the first edge after release.
- Latency, with acceptance at edge E0:
  - READ1 in cycle 1, READ2 in cycle 2, EXEC in cycle 3.
  - WB strobe during cycle 4; register write at E4.
  - IDLE/ready in cycle 5.
  - Throughput: one instruction per 5 cycles.
- Read-after-write: the E4 write is visible to the next instruction's READ1 (cycle ≥6). No forwarding is required.
- halt:
  - Sampled only in IDLE.
  - Asserting halt mid-instruction does not stop the instruction; it blocks the next acceptance.
- Reset mid-instruction aborts it: no regWrite and no count change afterwards.
- Holding instrValid with unchanged instrWord while not ready is legal. It must not cause a double accept.

## Structure
- Shared package cpu_pkg:
  - op localparams (OP_ADD…OP_XOR).
  - instrWord field bit positions.
  - State enum.
  - DATA_W/REG_AW defaults.
- The ALU is already defined in the package's op encoding.
- Flat FSM; no sub-module. The ALU and register file are instantiated beside the sequencer, not inside it.

## Test plan
- ADD, r1=5, r2=7, instr 000_011_001_010 → regWrite in cycle 4 with addr 3, data 0x000C; retiredCount = 1.
- SUB wrap, r1=0, r2=1, rd=4 → r4 = 0xFFFF; no other side effect.
- Back-to-back dependency: ADD r3=r1+r2, then XOR r5=r3^r1 presented while waiting → second accepted in cycle 5; r5 = 0x000C^0x0005 = 0x0009.
- Illegal op 110 → illegalOp high for exactly cycle 3, no regWrite, retiredCount unchanged, instrReady back in cycle 4.
- Reset asserted during READ2 → all outputs 0 immediately; no write ever issued for that instruction.
- halt held during IDLE with instrValid high for 10 cycles → instrReady stays 0; accepted the first cycle halt drops.
- Preload retiredCount to 0xFFFF by 65535 retirements (or force) → one more retirement gives 0x0000.
